// File: rtl/prg_loader_if.sv
// -----------------------------------------------------------------------------
// sdram_bus : request/acknowledge word bus between a loader and an SDRAM
//             controller.
//
// Signals
//   req        one-cycle request strobe (master -> slave)
//   we         1 = write, 0 = read (master -> slave)
//   address    word address, ADDR_W bits (master -> slave)
//   data_write 16-bit write data (master -> slave)
//   data_read  16-bit read data, valid with ack (slave -> master)
//   ack        one-cycle pulse completing the current request (slave -> master)
// -----------------------------------------------------------------------------
interface sdram_bus #(
   parameter int ADDR_W = 22
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] address;
   logic [15:0]       data_write;
   logic [15:0]       data_read;
   logic              ack;

   modport master (
      output req, we, address, data_write,
      input  data_read, ack
   );

   modport slave (
      input  req, we, address, data_write,
      output data_read, ack
   );
endinterface

// File: rtl/prg_loader.sv
// -----------------------------------------------------------------------------
// prg_loader : packs an incoming byte stream into 16-bit words and writes them
//              to consecutive SDRAM word addresses. The even byte of each pair
//              lands in the low half of the word; an odd trailing byte is
//              padded with 8'hFF in the high half.
//
// Optional feature: define PRG_LOADER_VERIFY_EN to read every word back after
// writing it and raise a sticky error flag on mismatch. Without the macro the
// read-back states do not exist and error is tied low.
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous active-high reset
//   start     one-cycle pulse starting a load (only honoured in IDLE)
//   base      first word address, sampled on accepted start
//   len       byte count, sampled on accepted start
//   in_valid  byte stream valid
//   in_ready  byte stream ready (high only while collecting bytes)
//   in_data   byte stream data
//   ram       sdram_bus master port
//   busy      high whenever not IDLE
//   done      one-cycle pulse when the load finishes
//   error     sticky read-back mismatch flag, cleared by accepted start
// -----------------------------------------------------------------------------
module prg_loader #(
   parameter int ADDR_W = 22,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   sdram_bus.master          ram,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE,
      LO,
      HI,
      WRITE,
      WAIT
`ifdef PRG_LOADER_VERIFY_EN
      ,
      RD,
      RWAIT
`endif
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr, addr_next;
   logic [LEN_W-1:0]  remaining, remaining_next;
   logic [15:0]       word, word_next;
   logic              done_q, done_next;

`ifdef PRG_LOADER_VERIFY_EN
   logic              err_q, err_next;
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   // The bus address and data are always the current word and address
   // registers; they are only meaningful while req is high, and both
   // registers clear on reset so the bus idles at zero.
   assign ram.address    = addr;
   assign ram.data_write = word;
   assign busy           = (state != IDLE);
   assign done           = done_q;

   // State and datapath registers. done is registered so that a zero-length
   // start produces its pulse on the following cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         word      <= '0;
         done_q    <= 1'b0;
`ifdef PRG_LOADER_VERIFY_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         addr      <= addr_next;
         remaining <= remaining_next;
         word      <= word_next;
         done_q    <= done_next;
`ifdef PRG_LOADER_VERIFY_EN
         err_q     <= err_next;
`endif
      end
   end

   // Next-state and output decode. The word finishes either after its high
   // byte or, when the stream runs out on a low byte, with an FF pad. A
   // completed word (or its read-back) advances the address and either
   // returns for more bytes or ends the load.
   always_comb begin
      state_next     = state;
      addr_next      = addr;
      remaining_next = remaining;
      word_next      = word;
      done_next      = 1'b0;
      in_ready       = 1'b0;
      ram.req        = 1'b0;
      ram.we         = 1'b0;
`ifdef PRG_LOADER_VERIFY_EN
      err_next       = err_q;
`endif

      case (state)
         IDLE: begin
            if (start) begin
`ifdef PRG_LOADER_VERIFY_EN
               err_next = 1'b0;
`endif
               if (len == '0) begin
                  done_next = 1'b1;
               end else begin
                  state_next     = LO;
                  addr_next      = base;
                  remaining_next = len;
               end
            end
         end

         LO: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_next[7:0] = in_data;
               remaining_next = remaining - LEN_W'(1);
               if (remaining != LEN_W'(1)) begin
                  state_next = HI;
               end else begin
                  word_next[15:8] = 8'hFF;
                  state_next      = WRITE;
               end
            end
         end

         HI: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_next[15:8] = in_data;
               remaining_next  = remaining - LEN_W'(1);
               state_next      = WRITE;
            end
         end

         WRITE: begin
            ram.req    = 1'b1;
            ram.we     = 1'b1;
            state_next = WAIT;
         end

         WAIT: begin
            if (ram.ack) begin
`ifdef PRG_LOADER_VERIFY_EN
               state_next = RD;
`else
               addr_next = addr + ADDR_W'(1);
               if (remaining != '0) begin
                  state_next = LO;
               end else begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
`endif
            end
         end

`ifdef PRG_LOADER_VERIFY_EN
         RD: begin
            ram.req    = 1'b1;
            state_next = RWAIT;
         end

         RWAIT: begin
            if (ram.ack) begin
               if (ram.data_read != word) begin
                  err_next = 1'b1;
               end
               addr_next = addr + ADDR_W'(1);
               if (remaining != '0) begin
                  state_next = LO;
               end else begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
`endif

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_prg_loader.sv
// -----------------------------------------------------------------------------
// tb_prg_loader : self-checking bench for prg_loader. An SDRAM slave model
// logs every request and acknowledges it after a programmable latency; a byte
// feeder drives the stream with random gaps. Each load is compared against a
// list of expected bus transactions computed from the byte list.
// -----------------------------------------------------------------------------
module tb_prg_loader;

   localparam int AW = 22;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base;
   logic [LW-1:0] len;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          busy;
   logic          done;
   logic          error;

   sdram_bus #(.ADDR_W(AW)) ram_if ();

   prg_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .len      (len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .ram      (ram_if),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } req_t;

   int          errors = 0;
   int          checks = 0;
   req_t        req_log[$];
   logic [7:0]  byte_q[$];
   logic [7:0]  next_bytes[$];
   logic [15:0] mem[int];
   int          ack_countdown = 0;
   int          ack_latency = 3;
   bit          random_latency = 1'b0;
   bit          corrupt_next_read = 1'b0;
   int          done_count = 0;
   bit          pending_xfer = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // SDRAM slave model: logs requests and pulses ack after the latency
   always @(negedge clk) begin
      ram_if.ack = 1'b0;
      if (ram_if.req === 1'b1) begin
         req_t r;
         checkOutput("req_while_outstanding", 32'(ack_countdown != 0), 32'd0);
         r.we   = ram_if.we;
         r.addr = ram_if.address;
         r.data = ram_if.data_write;
         req_log.push_back(r);
         if (ram_if.we) begin
            mem[int'(ram_if.address)] = ram_if.data_write;
         end else if (corrupt_next_read) begin
            ram_if.data_read  = 16'h0000;
            corrupt_next_read = 1'b0;
         end else if (mem.exists(int'(ram_if.address))) begin
            ram_if.data_read = mem[int'(ram_if.address)];
         end else begin
            ram_if.data_read = 16'h0000;
         end
         ack_countdown = random_latency ? int'($urandom_range(1, 4)) : ack_latency;
      end else if (ack_countdown > 0) begin
         ack_countdown--;
         if (ack_countdown == 0) ram_if.ack = 1'b1;
      end
   end

   // Byte feeder: pops a byte after each handshake, random valid gaps
   always @(negedge clk) begin
      if (pending_xfer && byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() > 0 && $urandom_range(0, 9) < 7) begin
         in_valid = 1'b1;
         in_data  = byte_q[0];
      end else begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
      pending_xfer = (in_valid && in_ready === 1'b1);
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
   end

   // Runs one load of next_bytes and compares the bus traffic against the
   // packing rule: word i = {byte 2i+1 (or FF), byte 2i} at base+i.
   task automatic applyStimulus(input logic [AW-1:0] b, input logic [LW-1:0] n,
                                input logic exp_err, input string tag);
      req_t exp_q[$];
      int   words;
      int   log_start;
      int   done_start;
      bit   seen;

      words = (int'(n) + 1) / 2;
      for (int i = 0; i < words; i++) begin
         req_t e;
         logic [7:0] lo;
         logic [7:0] hi;
         lo     = next_bytes[2*i];
         hi     = (2*i + 1 < int'(n)) ? next_bytes[2*i+1] : 8'hFF;
         e.we   = 1'b1;
         e.addr = b + AW'(i);
         e.data = {hi, lo};
         exp_q.push_back(e);
`ifdef PRG_LOADER_VERIFY_EN
         e.we = 1'b0;
         exp_q.push_back(e);
`endif
      end

      @(negedge clk);
      log_start  = req_log.size();
      done_start = done_count;
      foreach (next_bytes[i]) byte_q.push_back(next_bytes[i]);
      start = 1'b1;
      base  = b;
      len   = n;
      @(negedge clk);
      start = 1'b0;
      base  = AW'($urandom);
      len   = LW'($urandom);
      checkOutput($sformatf("%s error_cleared_or_zero", tag), 32'(error), 32'd0);

      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      checkOutput($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
      checkOutput($sformatf("%s busy_at_done", tag), 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("%s done_single_pulse", tag), 32'(done), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput($sformatf("%s done_count", tag), 32'(done_count - done_start), 32'd1);
      checkOutput($sformatf("%s error", tag), 32'(error), 32'(exp_err));
      checkOutput($sformatf("%s req_count", tag), 32'(req_log.size() - log_start),
                  32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && log_start + i < req_log.size(); i++) begin
         req_t r;
         r = req_log[log_start + i];
         checkOutput($sformatf("%s req%0d we", tag, i), 32'(r.we), 32'(exp_q[i].we));
         checkOutput($sformatf("%s req%0d addr", tag, i), 32'(r.addr), 32'(exp_q[i].addr));
         if (exp_q[i].we) begin
            checkOutput($sformatf("%s req%0d data", tag, i), 32'(r.data), 32'(exp_q[i].data));
         end
      end
      next_bytes.delete();
   endtask

   initial begin
      int          log_snap;
      bit          got_req;
      logic [AW-1:0] rb;
      logic [LW-1:0] rn;

      reset = 1'b1;
      start = 1'b0;
      base  = '0;
      len   = '0;
      ram_if.ack       = 1'b0;
      ram_if.data_read = 16'h0000;

      repeat (3) @(negedge clk);
      checkOutput("reset req", 32'(ram_if.req), 32'd0);
      checkOutput("reset we", 32'(ram_if.we), 32'd0);
      checkOutput("reset address", 32'(ram_if.address), 32'd0);
      checkOutput("reset data_write", 32'(ram_if.data_write), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset error", 32'(error), 32'd0);
      reset = 1'b0;

      // Even length, fixed 3-cycle ack
      ack_latency = 3;
      next_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(22'h000100, 16'd4, 1'b0, "len4");

      // Odd length pads high byte with FF
      next_bytes = '{8'hAA, 8'hBB, 8'hCC};
      applyStimulus(22'h012340, 16'd3, 1'b0, "len3");

      // Zero length: done only, no request
      applyStimulus(22'h000777, 16'd0, 1'b0, "len0");

      // Address wraps at the top of the word space
      next_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(22'h3FFFFF, 16'd4, 1'b0, "wrap");

      // Reset while waiting for ack; the late ack must be ignored
      ack_latency = 4;
      for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom));
      @(negedge clk);
      start = 1'b1;
      base  = 22'h000200;
      len   = 16'd6;
      @(negedge clk);
      start    = 1'b0;
      log_snap = req_log.size();
      got_req  = 1'b0;
      for (int c = 0; c < 500 && !got_req; c++) begin
         @(negedge clk);
         if (req_log.size() > log_snap) got_req = 1'b1;
      end
      checkOutput("rst_mid req_seen", 32'(got_req), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      byte_q.delete();
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_mid req", 32'(ram_if.req), 32'd0);
      checkOutput("rst_mid we", 32'(ram_if.we), 32'd0);
      checkOutput("rst_mid address", 32'(ram_if.address), 32'd0);
      checkOutput("rst_mid data_write", 32'(ram_if.data_write), 32'd0);
      checkOutput("rst_mid in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_mid busy", 32'(busy), 32'd0);
      checkOutput("rst_mid done", 32'(done), 32'd0);
      checkOutput("rst_mid error", 32'(error), 32'd0);
      log_snap = req_log.size();
      repeat (12) @(negedge clk);
      checkOutput("rst_mid no_new_req", 32'(req_log.size() - log_snap), 32'd0);
      checkOutput("rst_mid busy_after_ack", 32'(busy), 32'd0);
      next_bytes = '{8'h5A, 8'hA5, 8'h3C};
      applyStimulus(22'h000300, 16'd3, 1'b0, "after_rst");

`ifdef PRG_LOADER_VERIFY_EN
      // First read-back corrupted: error latches, then next start clears it
      ack_latency       = 3;
      corrupt_next_read = 1'b1;
      next_bytes        = '{8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(22'h000100, 16'd4, 1'b1, "verify_bad");
      next_bytes = '{8'h66, 8'h77};
      applyStimulus(22'h000400, 16'd2, 1'b0, "verify_clear");
`endif

      // Randomized loads with random ack latency
      random_latency = 1'b1;
      for (int t = 0; t < 10; t++) begin
         rb = AW'($urandom);
         if (t == 0) rb = 22'h3FFFFE;
         rn = LW'($urandom_range(1, 9));
         for (int i = 0; i < int'(rn); i++) next_bytes.push_back(8'($urandom));
         applyStimulus(rb, rn, 1'b0, $sformatf("rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
